// File: rtl/cond_branch_resolver.sv
// NZCV condition-flag register plus LEGv8 branch resolver (B.cond/CBZ/CBNZ/B) with a registered result.
// Define FLAG_BYPASS_EN to forward same-cycle flags to B.cond instead of stalling in HOLD.
module cond_branch_resolver #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_we,
    input  logic              Zero_in,
    input  logic              Neg_in,
    input  logic              C_in,
    input  logic              V_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [1:0]        br_kind,
    input  logic [3:0]        br_cond,
    input  logic              br_rt_zero,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] pc_plus4,
    output logic              out_valid,
    output logic              taken,
    output logic [ADDR_W-1:0] next_pc,
    output logic [3:0]        flags_q,
    output logic [CNT_W-1:0]  taken_cnt
);

    typedef enum logic [1:0] {
        KIND_BCOND = 2'b00,
        KIND_CBZ   = 2'b01,
        KIND_CBNZ  = 2'b10,
        KIND_B     = 2'b11
    } br_kind_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

`ifdef FLAG_BYPASS_EN
    localparam bit INTERLOCK = 1'b0;
`else
    localparam bit INTERLOCK = 1'b1;
`endif

    state_t     state, state_nx;
    logic [3:0] eval_flags;
    logic       n_f, z_f, c_f, v_f;
    logic       cond_ok;
    logic       taken_nx;
    logic       accept;

    always_comb begin
`ifdef FLAG_BYPASS_EN
        eval_flags = flag_we ? {Neg_in, Zero_in, C_in, V_in} : flags_q;
`else
        eval_flags = flags_q;
`endif
    end

    assign {n_f, z_f, c_f, v_f} = eval_flags;

    always_comb begin
        case (br_cond)
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = !z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = !c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = !n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = !v_f;
            4'b1000: cond_ok = c_f && !z_f;
            4'b1001: cond_ok = !c_f || z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = !z_f && (n_f == v_f);
            4'b1101: cond_ok = z_f || (n_f != v_f);
            default: cond_ok = 1'b1;  // AL and NV both always taken
        endcase
    end

    always_comb begin
        case (br_kind)
            KIND_BCOND: taken_nx = cond_ok;
            KIND_CBZ:   taken_nx = br_rt_zero;
            KIND_CBNZ:  taken_nx = !br_rt_zero;
            default:    taken_nx = 1'b1;
        endcase
    end

    // A B.cond arriving alongside a flag write must wait until the write has landed in flags_q.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nx = state;
        br_ready = 1'b1;
        case (state)
            IDLE: begin
                if (INTERLOCK && br_valid && (br_kind == KIND_BCOND) && flag_we) begin
                    br_ready = 1'b0;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (flag_we) begin
                    br_ready = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = br_valid && br_ready;

    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flags_q   <= 4'b0000;
            out_valid <= 1'b0;
            taken     <= 1'b0;
            next_pc   <= '0;
            taken_cnt <= '0;
        end else begin
            state     <= state_nx;
            out_valid <= accept;
            if (flag_we) begin
                flags_q <= {Neg_in, Zero_in, C_in, V_in};
            end
            if (accept) begin
                taken   <= taken_nx;
                next_pc <= taken_nx ? br_target : pc_plus4;
                if (taken_nx && (taken_cnt != '1)) begin
                    taken_cnt <= taken_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cond_branch_resolver.sv
// Directed self-checking bench for cond_branch_resolver; a second CNT_W=2 instance shares stimulus
// to exercise counter saturation.
module tb_cond_branch_resolver;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flag_we, zero_in, neg_in, c_in, v_in;
    logic              br_valid;
    logic [1:0]        br_kind;
    logic [3:0]        br_cond;
    logic              br_rt_zero;
    logic [ADDR_W-1:0] br_target, pc_plus4;

    logic              br_ready, out_valid, taken;
    logic [ADDR_W-1:0] next_pc;
    logic [3:0]        flags_q;
    logic [15:0]       taken_cnt;

    logic              s_br_ready, s_out_valid, s_taken;
    logic [ADDR_W-1:0] s_next_pc;
    logic [3:0]        s_flags_q;
    logic [1:0]        s_taken_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cond_branch_resolver #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .Zero_in(zero_in), .Neg_in(neg_in), .C_in(c_in), .V_in(v_in),
        .br_valid(br_valid), .br_ready(br_ready), .br_kind(br_kind), .br_cond(br_cond),
        .br_rt_zero(br_rt_zero), .br_target(br_target), .pc_plus4(pc_plus4),
        .out_valid(out_valid), .taken(taken), .next_pc(next_pc),
        .flags_q(flags_q), .taken_cnt(taken_cnt)
    );

    cond_branch_resolver #(.ADDR_W(ADDR_W), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .Zero_in(zero_in), .Neg_in(neg_in), .C_in(c_in), .V_in(v_in),
        .br_valid(br_valid), .br_ready(s_br_ready), .br_kind(br_kind), .br_cond(br_cond),
        .br_rt_zero(br_rt_zero), .br_target(br_target), .pc_plus4(pc_plus4),
        .out_valid(s_out_valid), .taken(s_taken), .next_pc(s_next_pc),
        .flags_q(s_flags_q), .taken_cnt(s_taken_cnt)
    );

    task automatic set_req(input logic v, input logic [1:0] k, input logic [3:0] c,
                           input logic rtz, input logic [ADDR_W-1:0] tgt,
                           input logic [ADDR_W-1:0] pc4);
        br_valid   = v;
        br_kind    = k;
        br_cond    = c;
        br_rt_zero = rtz;
        br_target  = tgt;
        pc_plus4   = pc4;
    endtask

    task automatic set_flags(input logic we, input logic n, input logic z,
                             input logic c, input logic v);
        flag_we = we;
        neg_in  = n;
        zero_in = z;
        c_in    = c;
        v_in    = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_req(1'b0, 2'b00, 4'h0, 1'b0, '0, '0);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags_q); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", taken); end
        checks++; if (next_pc !== '0) begin errors++; $display("FAIL reset_next_pc: got %h want 0", next_pc); end
        checks++; if (taken_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", taken_cnt); end
        checks++; if (s_taken_cnt !== 2'd0) begin errors++; $display("FAIL reset_small_cnt: got %0d want 0", s_taken_cnt); end
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", br_ready); end
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 2'b11, 4'h0, 1'b0, 64'h100 + 64'(i * 16), 64'h104 + 64'(i * 16));
            @(negedge clk);
            exp_cnt++;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (next_pc !== 64'h100 + 64'(i * 16)) begin errors++; $display("FAIL sat_pc[%0d]: got %h want %h", i, next_pc, 64'h100 + 64'(i * 16)); end
            checks++; if (taken_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, taken_cnt, exp_cnt); end
            checks++; if (s_taken_cnt !== 2'((exp_cnt > 3) ? 3 : exp_cnt)) begin errors++; $display("FAIL sat_small_cnt[%0d]: got %0d want %0d", i, s_taken_cnt, (exp_cnt > 3) ? 3 : exp_cnt); end
        end
        set_req(1'b0, 2'b00, 4'h0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (s_taken_cnt !== 2'd3) begin errors++; $display("FAIL sat_small_hold: got %0d want 3", s_taken_cnt); end
    endtask

    task automatic test_flag_eq;
        set_flags(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL eq_flags: got %b want 0100", flags_q); end
        set_req(1'b1, 2'b00, 4'b0000, 1'b0, 64'h1000, 64'h0404);
        #1;
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL eq_ready: got %b want 1", br_ready); end
        @(negedge clk);
        set_req(1'b0, 2'b00, 4'h0, 1'b0, '0, '0);
        exp_cnt++;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL eq_valid: got %b want 1", out_valid); end
        checks++; if (taken !== 1'b1) begin errors++; $display("FAIL eq_taken: got %b want 1", taken); end
        checks++; if (next_pc !== 64'h1000) begin errors++; $display("FAIL eq_pc: got %h want 1000", next_pc); end
        checks++; if (taken_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL eq_cnt: got %0d want %0d", taken_cnt, exp_cnt); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eq_pulse: got %b want 0", out_valid); end
        checks++; if (taken !== 1'b1 || next_pc !== 64'h1000) begin errors++; $display("FAIL eq_hold: got %b/%h want 1/1000", taken, next_pc); end
    endtask

    task automatic test_signed_conds;
        logic [3:0] conds [4];
        logic       exp_t [4];
        logic [ADDR_W-1:0] tgt, pc4;
        conds = '{4'b1010, 4'b1011, 4'b1100, 4'b1101};
        exp_t = '{1'b1, 1'b0, 1'b1, 1'b0};
        set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (flags_q !== 4'b1001) begin errors++; $display("FAIL sc_flags: got %b want 1001", flags_q); end
        for (int i = 0; i < 4; i++) begin
            tgt = 64'h2000 + 64'(i * 16);
            pc4 = 64'h2004 + 64'(i * 16);
            set_req(1'b1, 2'b00, conds[i], 1'b0, tgt, pc4);
            @(negedge clk);
            set_req(1'b0, 2'b00, 4'h0, 1'b0, '0, '0);
            if (exp_t[i]) exp_cnt++;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sc_valid[%b]: got %b want 1", conds[i], out_valid); end
            checks++; if (taken !== exp_t[i]) begin errors++; $display("FAIL sc_taken[%b]: got %b want %b", conds[i], taken, exp_t[i]); end
            checks++; if (next_pc !== (exp_t[i] ? tgt : pc4)) begin errors++; $display("FAIL sc_pc[%b]: got %h want %h", conds[i], next_pc, exp_t[i] ? tgt : pc4); end
            checks++; if (taken_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL sc_cnt[%b]: got %0d want %0d", conds[i], taken_cnt, exp_cnt); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sc_pulse[%b]: got %b want 0", conds[i], out_valid); end
        end
    endtask

    task automatic test_cbnz_flag_we;
        set_flags(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        set_req(1'b1, 2'b10, 4'h0, 1'b1, 64'h4000, 64'h4004);
        #1;
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL cbnz_ready: got %b want 1", br_ready); end
        @(negedge clk);
        set_req(1'b0, 2'b00, 4'h0, 1'b0, '0, '0);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cbnz_valid: got %b want 1", out_valid); end
        checks++; if (taken !== 1'b0) begin errors++; $display("FAIL cbnz_taken: got %b want 0", taken); end
        checks++; if (next_pc !== 64'h4004) begin errors++; $display("FAIL cbnz_pc: got %h want 4004", next_pc); end
        checks++; if (flags_q !== 4'b0110) begin errors++; $display("FAIL cbnz_flags: got %b want 0110", flags_q); end
    endtask

    task automatic test_back_to_back;
        set_req(1'b1, 2'b01, 4'h0, 1'b1, 64'h5000, 64'h5004);
        @(negedge clk);
        exp_cnt++;
        checks++; if (out_valid !== 1'b1 || taken !== 1'b1 || next_pc !== 64'h5000) begin errors++; $display("FAIL b2b_cbz: got %b/%b/%h want 1/1/5000", out_valid, taken, next_pc); end
        set_req(1'b1, 2'b11, 4'h0, 1'b0, 64'h6000, 64'h6004);
        #1;
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", br_ready); end
        @(negedge clk);
        exp_cnt++;
        checks++; if (out_valid !== 1'b1 || taken !== 1'b1 || next_pc !== 64'h6000) begin errors++; $display("FAIL b2b_b: got %b/%b/%h want 1/1/6000", out_valid, taken, next_pc); end
        set_req(1'b1, 2'b01, 4'h0, 1'b0, 64'h7000, 64'h7004);
        @(negedge clk);
        set_req(1'b0, 2'b00, 4'h0, 1'b0, '0, '0);
        checks++; if (out_valid !== 1'b1 || taken !== 1'b0 || next_pc !== 64'h7004) begin errors++; $display("FAIL b2b_cbz_nt: got %b/%b/%h want 1/0/7004", out_valid, taken, next_pc); end
        checks++; if (taken_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d want %0d", taken_cnt, exp_cnt); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_hazard;
        set_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (flags_q !== 4'b0000) begin errors++; $display("FAIL hz_flags0: got %b want 0000", flags_q); end
        set_flags(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        set_req(1'b1, 2'b00, 4'b0000, 1'b0, 64'h8000, 64'h8004);
        #1;
`ifndef FLAG_BYPASS_EN
        checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL hz_stall: got %b want 0", br_ready); end
        @(negedge clk);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL hz_release: got %b want 1", br_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hz_no_result: got %b want 0", out_valid); end
`else
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL hz_bypass_ready: got %b want 1", br_ready); end
`endif
        @(negedge clk);
        set_req(1'b0, 2'b00, 4'h0, 1'b0, '0, '0);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cnt++;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hz_valid: got %b want 1", out_valid); end
        checks++; if (taken !== 1'b1 || next_pc !== 64'h8000) begin errors++; $display("FAIL hz_result: got %b/%h want 1/8000", taken, next_pc); end
        checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL hz_flags: got %b want 0100", flags_q); end
        checks++; if (taken_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL hz_cnt: got %0d want %0d", taken_cnt, exp_cnt); end
    endtask

    task automatic test_reset_in_hold;
        set_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_req(1'b1, 2'b00, 4'b0000, 1'b0, 64'h9000, 64'h9004);
        @(negedge clk);
        #1;
`ifndef FLAG_BYPASS_EN
        checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL rh_hold: got %b want 0", br_ready); end
`else
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL rh_bypass_ready: got %b want 1", br_ready); end
`endif
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (flags_q !== 4'b0000 || out_valid !== 1'b0 || taken !== 1'b0) begin errors++; $display("FAIL rh_async: got %b/%b/%b want 0000/0/0", flags_q, out_valid, taken); end
        checks++; if (next_pc !== '0 || taken_cnt !== 16'd0) begin errors++; $display("FAIL rh_async_pc_cnt: got %h/%0d want 0/0", next_pc, taken_cnt); end
        set_req(1'b0, 2'b00, 4'b0000, 1'b0, 64'h9000, 64'h9004);
        #1;
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL rh_idle: got %b want 1", br_ready); end
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_req(1'b1, 2'b00, 4'b0000, 1'b0, 64'h9000, 64'h9004);
        #1;
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL rh_re_ready: got %b want 1", br_ready); end
        @(negedge clk);
        set_req(1'b0, 2'b00, 4'h0, 1'b0, '0, '0);
        checks++; if (out_valid !== 1'b1 || taken !== 1'b0 || next_pc !== 64'h9004) begin errors++; $display("FAIL rh_re_result: got %b/%b/%h want 1/0/9004", out_valid, taken, next_pc); end
        checks++; if (taken_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL rh_re_cnt: got %0d want %0d", taken_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_reset();
        test_flag_eq();
        test_signed_conds();
        test_cbnz_flag_we();
        test_back_to_back();
        test_hazard();
        test_reset_in_hold();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
